// File: rtl/execute_forward_if.sv
// Bundle of decode-side inputs and EX-stage outputs for the execute/forward stage.
// The master modport is the upstream driver (decode, later stages, or a bench).
// The slave modport is the execute stage itself.
interface execute_forward_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] ans_dm;
    logic [WIDTH-1:0] ans_wb;
    logic [1:0]       mux_sel_a;
    logic [1:0]       mux_sel_b;
    logic             imm_sel;
    logic [7:0]       Imm;
    logic [4:0]       op_dec;
    logic [4:0]       RW_dec;
    logic             mem_en_dec;
    logic             mem_rw_dec;
    logic             mem_mux_sel_dec;

    logic [WIDTH-1:0] ans_ex;
    logic [WIDTH-1:0] DM_data;
    logic [4:0]       RW_ex;
    logic             mem_en_ex;
    logic             mem_rw_ex;
    logic             mem_mux_sel_ex;
    logic             flag_z;
    logic             flag_c;

    modport master (
        output A, B, ans_dm, ans_wb, mux_sel_a, mux_sel_b, imm_sel, Imm,
               op_dec, RW_dec, mem_en_dec, mem_rw_dec, mem_mux_sel_dec,
        input  ans_ex, DM_data, RW_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_ex,
               flag_z, flag_c
    );

    modport slave (
        input  A, B, ans_dm, ans_wb, mux_sel_a, mux_sel_b, imm_sel, Imm,
               op_dec, RW_dec, mem_en_dec, mem_rw_dec, mem_mux_sel_dec,
        output ans_ex, DM_data, RW_ex, mem_en_ex, mem_rw_ex, mem_mux_sel_ex,
               flag_z, flag_c
    );
endinterface

// File: rtl/execute_forward_stage.sv
// Execute stage with operand forwarding.
// Each operand is picked from the register file, this stage's own previous
// result, the memory-stage result or the write-back result. The second operand
// may instead be the zero-extended immediate. The ALU result, flags, store
// data and memory controls are registered for the data-memory stage.
module execute_forward_stage #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    execute_forward_if.slave    bus
);

    typedef enum logic [1:0] {
        SRC_REG = 2'b00,
        SRC_EX  = 2'b01,
        SRC_DM  = 2'b10,
        SRC_WB  = 2'b11
    } fwd_src_e;

    typedef enum logic [2:0] {
        FN_ADD = 3'b000,
        FN_SUB = 3'b001,
        FN_MOV = 3'b010,
        FN_AND = 3'b011,
        FN_OR  = 3'b100,
        FN_XOR = 3'b101,
        FN_NOT = 3'b110,
        FN_SLA = 3'b111
    } alu_fn_e;

    logic [WIDTH-1:0] r_ans_ex;
    logic [WIDTH-1:0] r_dm_data;
    logic [4:0]       r_rw_ex;
    logic             r_mem_en_ex;
    logic             r_mem_rw_ex;
    logic             r_mem_mux_sel_ex;
    logic             r_flag_z;
    logic             r_flag_c;

    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_bf;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_flags_update;
    alu_fn_e          w_fn;

    // Source 01 deliberately reads the registered ans_ex, giving the
    // one-cycle-old result needed by back-to-back dependent instructions.
    function automatic logic [WIDTH-1:0] forwardMux(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] regVal,
        input logic [WIDTH-1:0] exVal,
        input logic [WIDTH-1:0] dmVal,
        input logic [WIDTH-1:0] wbVal
    );
        logic [WIDTH-1:0] val;
        case (fwd_src_e'(sel))
            SRC_REG: val = regVal;
            SRC_EX:  val = exVal;
            SRC_DM:  val = dmVal;
            default: val = wbVal;
        endcase
        return val;
    endfunction

    assign w_op_a  = forwardMux(bus.mux_sel_a, bus.A, r_ans_ex, bus.ans_dm, bus.ans_wb);
    assign w_op_bf = forwardMux(bus.mux_sel_b, bus.B, r_ans_ex, bus.ans_dm, bus.ans_wb);
    assign w_op_b  = bus.imm_sel ? WIDTH'(bus.Imm) : w_op_bf;

    // One extra bit on each arithmetic path holds carry, borrow, or the last
    // bit shifted out of the left shift. A zero shift leaves that bit at 0.
    assign w_sum  = {1'b0, w_op_a} + {1'b0, w_op_b};
    assign w_diff = {1'b0, w_op_a} - {1'b0, w_op_b};
    assign w_shl  = {1'b0, w_op_a} << w_op_b[3:0];
    assign w_fn   = alu_fn_e'(bus.op_dec[2:0]);

    // Pick the result and decide whether this opcode refreshes the flags.
    always_comb begin
        w_result       = '0;
        w_carry        = 1'b0;
        w_flags_update = 1'b0;
        if (!bus.op_dec[4]) begin
            w_flags_update = 1'b1;
            case (w_fn)
                FN_ADD: begin
                    w_result = w_sum[WIDTH-1:0];
                    w_carry  = w_sum[WIDTH];
                end
                FN_SUB: begin
                    w_result = w_diff[WIDTH-1:0];
                    w_carry  = w_diff[WIDTH];
                end
                FN_MOV: w_result = w_op_b;
                FN_AND: w_result = w_op_a & w_op_b;
                FN_OR:  w_result = w_op_a | w_op_b;
                FN_XOR: w_result = w_op_a ^ w_op_b;
                FN_NOT: w_result = ~w_op_b;
                default: begin
                    w_result = w_shl[WIDTH-1:0];
                    w_carry  = w_shl[WIDTH];
                end
            endcase
        end else if (bus.op_dec[4:1] == 4'b1010) begin
            w_result = w_op_b;
        end else begin
            w_result = '0;
        end
    end

    // Pipeline register toward the data-memory stage; flags hold on non-ALU ops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ans_ex         <= '0;
            r_dm_data        <= '0;
            r_rw_ex          <= '0;
            r_mem_en_ex      <= 1'b0;
            r_mem_rw_ex      <= 1'b0;
            r_mem_mux_sel_ex <= 1'b0;
            r_flag_z         <= 1'b0;
            r_flag_c         <= 1'b0;
        end else begin
            r_ans_ex         <= w_result;
            r_dm_data        <= w_op_bf;
            r_rw_ex          <= bus.RW_dec;
            r_mem_en_ex      <= bus.mem_en_dec;
            r_mem_rw_ex      <= bus.mem_rw_dec;
            r_mem_mux_sel_ex <= bus.mem_mux_sel_dec;
            if (w_flags_update) begin
                r_flag_z <= (w_result == '0);
                r_flag_c <= w_carry;
            end
        end
    end

    assign bus.ans_ex         = r_ans_ex;
    assign bus.DM_data        = r_dm_data;
    assign bus.RW_ex          = r_rw_ex;
    assign bus.mem_en_ex      = r_mem_en_ex;
    assign bus.mem_rw_ex      = r_mem_rw_ex;
    assign bus.mem_mux_sel_ex = r_mem_mux_sel_ex;
    assign bus.flag_z         = r_flag_z;
    assign bus.flag_c         = r_flag_c;

endmodule
